// File: rtl/lift_controller.sv
// Three-floor SCAN lift controller: latches floor calls, moves one floor per hop, dwells at served floors.
// Latency: one cycle from a call pulse to the decision that uses it; there is no backpressure, calls are always accepted.
module lift_controller #(
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] dstn,
  output logic       at_floor1,
  output logic       at_floor2,
  output logic       at_floor3
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN
  } state_t;

  state_t        r_state;
  logic [1:0]    r_pos;
  logic          r_dir_up;
  logic [2:0]    r_pending;
  logic [TW-1:0] r_travel_cnt;
  logic [DW-1:0] r_door_cnt;
  logic [2:0]    r_at;

  state_t        w_state_nxt;
  logic [1:0]    w_pos_nxt;
  logic          w_dir_up_nxt;
  logic [2:0]    w_clear;
  logic [2:0]    w_pending_nxt;
  logic [TW-1:0] w_travel_cnt_nxt;
  logic [DW-1:0] w_door_cnt_nxt;
  logic [2:0]    w_at_nxt;

  logic          w_here;
  logic          w_above;
  logic          w_below;
  logic [1:0]    w_arr_pos;
  logic          w_arr_here;
  logic          w_arr_further;
  state_t        w_dec_state;
  logic          w_dec_dir_up;
  logic [2:0]    w_dec_clear;

  // Request summaries relative to the car, plus the idle-style SCAN decision.
  always_comb begin
    w_here  = 1'b0;
    w_above = 1'b0;
    w_below = 1'b0;
    case (r_pos)
      2'd0: begin
        w_here  = r_pending[0];
        w_above = |r_pending[2:1];
      end
      2'd1: begin
        w_here  = r_pending[1];
        w_above = r_pending[2];
        w_below = r_pending[0];
      end
      default: begin
        w_here  = r_pending[2];
        w_below = |r_pending[1:0];
      end
    endcase

    w_arr_pos     = (r_state == S_MOVE_UP) ? (r_pos + 2'd1) : (r_pos - 2'd1);
    w_arr_here    = 1'b0;
    w_arr_further = 1'b0;
    case (w_arr_pos)
      2'd0:    w_arr_here = r_pending[0];
      2'd1: begin
        w_arr_here    = r_pending[1];
        w_arr_further = (r_state == S_MOVE_UP) ? r_pending[2] : r_pending[0];
      end
      default: w_arr_here = r_pending[2];
    endcase

    w_dec_state  = S_IDLE;
    w_dec_dir_up = r_dir_up;
    w_dec_clear  = 3'b000;
    if (w_here) begin
      w_dec_state = S_DOOR_OPEN;
      w_dec_clear = 3'b001 << r_pos;
    end else if (w_above && (r_dir_up || !w_below)) begin
      w_dec_state  = S_MOVE_UP;
      w_dec_dir_up = 1'b1;
    end else if (w_below) begin
      w_dec_state  = S_MOVE_DOWN;
      w_dec_dir_up = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_dir_up_nxt     = r_dir_up;
    w_clear          = 3'b000;
    w_travel_cnt_nxt = r_travel_cnt;
    w_door_cnt_nxt   = r_door_cnt;
    case (r_state)
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (r_travel_cnt != '0) begin
          w_travel_cnt_nxt = r_travel_cnt - 1'b1;
        end else begin
          w_pos_nxt = w_arr_pos;
          if (w_arr_here) begin
            w_state_nxt    = S_DOOR_OPEN;
            w_clear        = 3'b001 << w_arr_pos;
            w_door_cnt_nxt = DOOR_LOAD;
          end else if (w_arr_further) begin
            w_travel_cnt_nxt = TRAVEL_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DOOR_OPEN: begin
        if (w_here) begin
          w_clear        = 3'b001 << r_pos;
          w_door_cnt_nxt = DOOR_LOAD;
        end else if (r_door_cnt != '0) begin
          w_door_cnt_nxt = r_door_cnt - 1'b1;
        end else begin
          w_state_nxt      = w_dec_state;
          w_dir_up_nxt     = w_dec_dir_up;
          w_clear          = w_dec_clear;
          w_travel_cnt_nxt = TRAVEL_LOAD;
          w_door_cnt_nxt   = DOOR_LOAD;
        end
      end
      default: begin
        w_state_nxt      = w_dec_state;
        w_dir_up_nxt     = w_dec_dir_up;
        w_clear          = w_dec_clear;
        w_travel_cnt_nxt = TRAVEL_LOAD;
        w_door_cnt_nxt   = DOOR_LOAD;
      end
    endcase
    w_pending_nxt = (r_pending | dstn) & ~w_clear;
  end

  always_comb begin
    w_at_nxt = 3'b001 << w_pos_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pos        <= 2'd0;
      r_dir_up     <= 1'b1;
      r_pending    <= 3'b000;
      r_travel_cnt <= '0;
      r_door_cnt   <= '0;
      r_at         <= 3'b001;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_dir_up     <= w_dir_up_nxt;
      r_pending    <= w_pending_nxt;
      r_travel_cnt <= w_travel_cnt_nxt;
      r_door_cnt   <= w_door_cnt_nxt;
      r_at         <= w_at_nxt;
    end
  end

  assign at_floor1 = r_at[0];
  assign at_floor2 = r_at[1];
  assign at_floor3 = r_at[2];

endmodule

// File: tb/tb_lift_controller.sv
// Randomized bench for lift_controller against a floor/call-list model, plus literal checkpoints on known sequences.
module tb_lift_controller;

  localparam int TRAVEL = 2;
  localparam int DOOR   = 1;
  localparam int REST = 0, MOVING = 1, DWELL = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dstn;
  logic       at_floor1, at_floor2, at_floor3;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  typedef struct {
    int       floor;
    int       mode;
    bit       up;
    bit [3:1] req;
    int       left;
  } model_t;

  model_t m = '{floor: 1, mode: REST, up: 1'b1, req: 3'b000, left: 0};

  lift_controller #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .reset(reset), .dstn(dstn),
    .at_floor1(at_floor1), .at_floor2(at_floor2), .at_floor3(at_floor3)
  );

  always #5 clk = ~clk;

  // SCAN choice from rest: serve here, else keep heading, else turn round.
  function automatic model_t decide(model_t n, output bit [3:1] clr);
    bit above = 1'b0;
    bit below = 1'b0;
    clr = 3'b000;
    for (int f = 1; f <= 3; f++) begin
      if (n.req[f] && f > n.floor) above = 1'b1;
      if (n.req[f] && f < n.floor) below = 1'b1;
    end
    if (n.req[n.floor]) begin
      n.mode = DWELL; n.left = DOOR - 1; clr[n.floor] = 1'b1;
    end else if (above && (n.up || !below)) begin
      n.mode = MOVING; n.up = 1'b1; n.left = TRAVEL - 1;
    end else if (below) begin
      n.mode = MOVING; n.up = 1'b0; n.left = TRAVEL - 1;
    end else begin
      n.mode = REST;
    end
    return n;
  endfunction

  function automatic model_t step(model_t mi, logic rst, logic [2:0] d);
    model_t   n = mi;
    bit [3:1] clr = 3'b000;
    bit       further = 1'b0;
    if (rst) begin
      n.floor = 1; n.mode = REST; n.up = 1'b1; n.req = 3'b000; n.left = 0;
      return n;
    end
    case (mi.mode)
      MOVING: begin
        if (mi.left > 0) begin
          n.left = mi.left - 1;
        end else begin
          n.floor = mi.up ? mi.floor + 1 : mi.floor - 1;
          for (int f = 1; f <= 3; f++)
            if (mi.req[f] && (mi.up ? f > n.floor : f < n.floor)) further = 1'b1;
          if (mi.req[n.floor]) begin
            n.mode = DWELL; n.left = DOOR - 1; clr[n.floor] = 1'b1;
          end else if (further) begin
            n.left = TRAVEL - 1;
          end else begin
            n.mode = REST;
          end
        end
      end
      DWELL: begin
        if (mi.req[mi.floor]) begin
          n.left = DOOR - 1; clr[mi.floor] = 1'b1;
        end else if (mi.left > 0) begin
          n.left = mi.left - 1;
        end else begin
          n = decide(mi, clr);
        end
      end
      default: n = decide(mi, clr);
    endcase
    n.req = (mi.req | d) & ~clr;
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step(m, reset, dstn);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] exp_at;
      exp_at = 3'b001 << (m.floor - 1);
      n_vec++;
      if ({at_floor3, at_floor2, at_floor1} !== exp_at) begin
        n_bad++;
        $display("FAIL model_cmp cycle %0d: at_floor[3:1] got %b expected %b", cyc,
                 {at_floor3, at_floor2, at_floor1}, exp_at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] d);
    @(negedge clk);
    dstn = d;
    @(negedge clk);
    dstn = 3'b000;
  endtask

  task automatic check_lit(input string name, input logic [2:0] exp_at);
    n_vec++;
    if ({at_floor3, at_floor2, at_floor1} !== exp_at) begin
      n_bad++;
      $display("FAIL %s: at_floor[3:1] got %b expected %b", name,
               {at_floor3, at_floor2, at_floor1}, exp_at);
    end
  endtask

  initial begin
    reset = 1'b1;
    dstn  = 3'b000;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check_lit("reset_floor1", 3'b001);
    tick(4);
    check_lit("idle_floor1", 3'b001);

    pulse(3'b001);
    tick(1); check_lit("same_floor_door", 3'b001);
    tick(3); check_lit("same_floor_idle", 3'b001);

    pulse(3'b010);
    tick(2); check_lit("up1_in_travel", 3'b001);
    tick(1); check_lit("up1_arrive2", 3'b010);
    tick(3); check_lit("up1_idle2", 3'b010);

    pulse(3'b101);
    tick(2); check_lit("scan_travel_up", 3'b010);
    tick(1); check_lit("scan_arrive3", 3'b100);
    tick(2); check_lit("scan_leave3", 3'b100);
    tick(1); check_lit("scan_pass2", 3'b010);
    tick(1); check_lit("scan_still2", 3'b010);
    tick(1); check_lit("scan_arrive1", 3'b001);
    tick(3);

    pulse(3'b100);
    tick(3); check_lit("to3_pass2", 3'b010);
    tick(2); check_lit("to3_arrive3", 3'b100);
    tick(3);

    pulse(3'b111);
    tick(3); check_lit("all_dwell3", 3'b100);
    tick(1); check_lit("all_stop2", 3'b010);
    tick(2); check_lit("all_leave2", 3'b010);
    tick(1); check_lit("all_stop1", 3'b001);
    tick(3);

    pulse(3'b100);
    tick(1); check_lit("rst_mid_moving", 3'b001);
    reset = 1'b1;
    tick(1); check_lit("rst_mid_applied", 3'b001);
    reset = 1'b0;
    tick(8); check_lit("rst_mid_no_move", 3'b001);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      dstn  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    end
    @(negedge clk);
    reset = 1'b0;
    dstn  = 3'b000;
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lift_controller.md
Name: lift_controller

Overview:
Three-floor lift (elevator) controller. Accepts floor-request pulses on a 3-bit one-hot-per-floor bus and latches them as pending calls. It moves the car one floor at a time using a SCAN (keep-direction) policy and stops at each requested floor for a door dwell. It reports the car position on three one-hot floor outputs and sits between the call-button logic and the floor indicator/motor interface.

Parameters:
TRAVEL_CYCLES, 2, clock cycles needed to travel between adjacent floors (>=1)
DOOR_CYCLES, 1, clock cycles the car dwells with the door open at a serviced floor (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
dstn  input  3  floor requests: bit0 = floor 1, bit1 = floor 2, bit2 = floor 3; any combination is legal, 000 = no request
at_floor1  output  1  high when the car position is floor 1
at_floor2  output  1  high when the car position is floor 2
at_floor3  output  1  high when the car position is floor 3

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset (sampled at a rising edge, overriding everything, including mid-travel): position = floor 1, state = IDLE, direction = UP, pending = 000, counters = 0. Outputs after reset: at_floor1 = 1, at_floor2 = 0, at_floor3 = 0.
- at_floorN is a registered decode of the position register. Exactly one output is high at all times. The position changes only on arrival, so the outputs hold the last floor during travel.
- Request capture on every edge: pending <= (pending | dstn) & ~clear_mask.
  - clear_mask is the bit of a floor serviced on that edge.
  - A dstn bit held for several cycles is equivalent to a single pulse.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. All decisions use registered pending, which gives one cycle of input latency.
- IDLE:
  - If pending[pos]: go to DOOR_OPEN, clear that bit, load the dwell counter with DOOR_CYCLES-1.
  - Else choose a direction:
    - If requests exist above and (direction = UP or no requests below): go to MOVE_UP.
    - Else if requests exist below: go to MOVE_DOWN.
    - Else stay in IDLE.
  - On entering a MOVE state, set direction to match and load the travel counter with TRAVEL_CYCLES-1.
- MOVE_UP / MOVE_DOWN:
  - Decrement the travel counter each cycle. On the edge where it is 0, position moves by ±1 (arrival).
  - On arrival, if pending[new pos] is set (including requests registered during travel): go to DOOR_OPEN and clear that bit.
  - On arrival otherwise:
    - If requests remain further in the same direction, reload the counter and keep moving.
    - Otherwise go to IDLE.
  - Position is never driven beyond floor 1 or floor 3; MOVE_UP is never entered at floor 3, nor MOVE_DOWN at floor 1.
- DOOR_OPEN:
  - Decrement the dwell counter. When it reaches 0, apply the IDLE decision rules on the same edge, so a pending call departs without an extra IDLE cycle.
  - A new request for the current floor during DOOR_OPEN is cleared immediately and restarts the dwell count.
- Requests for the floor just departed stay pending and are serviced on the return sweep.
- Simultaneous requests (e.g. 011, 111) are all latched. Service order follows SCAN from the current position and direction.

Test Plan:
- Reset held 2 cycles with dstn = 000 -> at_floor1 = 1, at_floor2 = at_floor3 = 0, and they remain so with no requests.
- From floor 1 idle, pulse dstn = 001 for 1 cycle -> stays at floor 1 (DOOR_OPEN for 1 cycle, then IDLE); at_floor1 remains 1 throughout.
- From floor 1 idle, pulse dstn = 010 at sampling edge E0 -> state MOVE_UP at E1; at_floor2 = 1 and at_floor1 = 0 after E3; DOOR_OPEN at E3, IDLE at E4.
- From floor 2 idle, pulse dstn = 101 -> direction UP is kept: reaches floor 3 (door opens), then travels down through floor 2 without stopping and arrives at floor 1; pending = 000 at the end.
- From floor 3, pulse dstn = 111 -> floor 3 is serviced in place, then the car stops at floor 2 and then floor 1; each hop is 2 cycles, each dwell is 1 cycle.
- Assert reset while in MOVE_UP between floors 1 and 2 with floor 3 pending -> on the next edge at_floor1 = 1, pending is cleared, state is IDLE, and no further movement occurs.
